// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, state encoding and address packing for the board renderer
//
// Board geometry (ROWS x COLS), palette constants, the drawer FSM state type
// and the {row, col} board RAM address packing helper.
package board_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    localparam logic [2:0] C_EMPTY = 3'b111;
    localparam logic [2:0] C_P1    = 3'b100;
    localparam logic [2:0] C_P2    = 3'b110;
    localparam logic [2:0] C_GRID  = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DRAW,
        DONE
    } state_t;

    // Column occupies the low three bits so a row is one aligned block of 8.
    function automatic logic [5:0] pack_addr(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/cell_sweep.sv
// rtl/cell_sweep.sv - px/py raster counter covering one CELL x CELL square
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero px/py at the next edge (takes priority over en)
//   en         : advance one pixel, px fastest, then py
//   px_d, py_d : coordinates that will be current after the next edge
//   last       : current pixel is the bottom-right corner of the cell
module cell_sweep #(
    parameter int CELL = 16,
    localparam int W   = $clog2(CELL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] px_d,
    output logic [W-1:0] py_d,
    output logic         last
);

    logic [W-1:0] px_q;
    logic [W-1:0] py_q;

    // CELL is a power of two, so the counters wrap naturally after the corner.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clear) begin
            px_d = '0;
            py_d = '0;
        end else if (en) begin
            px_d = px_q + W'(1);
            if (px_q == W'(CELL - 1)) begin
                py_d = py_q + W'(1);
            end
        end
    end

    assign last = (px_q == W'(CELL - 1)) && (py_q == W'(CELL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

endmodule

// File: rtl/board_drawer.sv
// rtl/board_drawer.sv - renders the 7x6 board RAM as coloured squares on the VGA pixel port
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle full-redraw request (ignored unless idle)
//   ram_addr/ram_rdata: board RAM read port, data one cycle after address
//   x, y, colour, plot: registered pixel write to the VGA adapter
//   busy              : redraw in progress
//   draw_done         : one-cycle pulse after the last pixel
module board_drawer
    import board_pkg::*;
#(
    parameter int         CELL        = 16,
    parameter int         X0          = 24,
    parameter int         Y0          = 12,
    parameter logic [2:0] GRID_COLOUR = C_GRID
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] ram_addr,
    input  logic [2:0] ram_rdata,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       draw_done
);

    localparam int W = $clog2(CELL);

    state_t     state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] cell_colour_q, cell_colour_d;
    logic [5:0] ram_addr_q, ram_addr_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       draw_done_q, draw_done_d;

    logic [W-1:0] px_d, py_d;
    logic         sweep_last;
    logic         board_last;

    cell_sweep #(.CELL(CELL)) u_sweep (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == WAIT),
        .en    (state_q == DRAW),
        .px_d  (px_d),
        .py_d  (py_d),
        .last  (sweep_last)
    );

    assign board_last = (col_q == 3'(COLS - 1)) && (row_q == 3'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = WAIT;
            WAIT:    state_d = DRAW;
            DRAW:    if (sweep_last) state_d = board_last ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state, so plot/x/y/colour
    // line up with the DRAW cycle of the pixel they describe.
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        cell_colour_d = cell_colour_q;
        ram_addr_d    = ram_addr_q;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = (state_d == DRAW);
        busy_d        = state_d inside {READ, WAIT, DRAW};
        draw_done_d   = (state_d == DONE);

        if (state_q == IDLE) begin
            row_d = '0;
            col_d = '0;
        end

        if (state_q == DRAW && sweep_last) begin
            if (col_q == 3'(COLS - 1)) begin
                col_d = '0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end

        // The first pixel of a cell is produced while the RAM word is still
        // on ram_rdata, so the colour source is the next-value of the register.
        if (state_q == WAIT) begin
            cell_colour_d = ram_rdata;
        end

        if (state_d == READ) begin
            ram_addr_d = pack_addr(row_d, col_d);
        end

        if (state_d == DRAW) begin
            x_d = 8'(X0) + 8'(col_q) * 8'(CELL) + 8'(px_d);
            y_d = 7'(Y0) + 7'(row_q) * 7'(CELL) + 7'(py_d);
            colour_d = (px_d == W'(CELL - 1) || py_d == W'(CELL - 1)) ? GRID_COLOUR : cell_colour_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            cell_colour_q <= '0;
            ram_addr_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            draw_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            cell_colour_q <= cell_colour_d;
            ram_addr_q    <= ram_addr_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            draw_done_q   <= draw_done_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign draw_done = draw_done_q;

endmodule

// File: tb/tb_board_drawer.sv
// tb/tb_board_drawer.sv - frame-timeline model and randomized redraw scenarios for board_drawer
module tb_board_drawer;
    import board_pkg::*;

    localparam int CELL = 16;
    localparam int X0   = 24;
    localparam int Y0   = 12;
    localparam int P    = 2 + CELL * CELL;
    localparam int NF   = 42 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] ram_addr;
    logic [2:0] ram_rdata;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       draw_done;

    logic [2:0] mem [64];

    board_drawer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .draw_done (draw_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: position t within a frame fixes everything -- cell k, its offset
    // inside the 2+CELL^2 slot, and from that the pixel and its colour.
    bit         live = 1'b0;
    bit         active = 1'b0;
    int         t = 0;
    int         cyc = 0;
    int         acc = 0;
    int         mk, moff, mrow, mcol, mpx, mpy;
    logic [7:0] ex_x = '0;
    logic [6:0] ex_y = '0;
    logic [2:0] ex_c = '0;
    logic [5:0] ex_addr = '0;
    logic       ex_plot = 1'b0;
    logic       ex_busy = 1'b0;
    logic       ex_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            live = 1'b1;
            active = 1'b0;
            t = 0;
            ex_x = '0;
            ex_y = '0;
            ex_c = '0;
            ex_addr = '0;
        end else if (active) begin
            t++;
            if (t == NF + 2) active = 1'b0;
        end else if (start) begin
            active = 1'b1;
            t = 1;
            acc = cyc;
        end
        ex_plot = 1'b0;
        ex_busy = 1'b0;
        ex_done = 1'b0;
        if (active && t <= NF) begin
            mk   = (t - 1) / P;
            moff = (t - 1) % P;
            mrow = mk / 7;
            mcol = mk % 7;
            ex_busy = 1'b1;
            if (moff == 0) begin
                ex_addr = 6'(mrow * 8 + mcol);
            end else if (moff >= 2) begin
                mpx = (moff - 2) % CELL;
                mpy = (moff - 2) / CELL;
                ex_plot = 1'b1;
                ex_x = 8'(X0 + mcol * CELL + mpx);
                ex_y = 7'(Y0 + mrow * CELL + mpy);
                ex_c = (mpx == CELL - 1 || mpy == CELL - 1) ? C_GRID : mem[mrow * 8 + mcol];
            end
        end else if (active && t == NF + 1) begin
            ex_done = 1'b1;
        end
    end

    int   n_plot, n_done, done_t, n_busy, n_other;
    int   red_n, red_minx, red_maxx, red_miny, red_maxy;
    logic [2:0] grid_c;
    bit   addr_seen [64];

    task automatic clear_stats();
        n_plot = 0; n_done = 0; done_t = 0; n_busy = 0; n_other = 0;
        red_n = 0; red_minx = 255; red_maxx = 0; red_miny = 255; red_maxy = 0;
        grid_c = 3'b000;
        for (int i = 0; i < 64; i++) addr_seen[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("plot", 32'(plot), 32'(ex_plot));
            chk("busy", 32'(busy), 32'(ex_busy));
            chk("draw_done", 32'(draw_done), 32'(ex_done));
            chk("ram_addr", 32'(ram_addr), 32'(ex_addr));
            chk("x", 32'(x), 32'(ex_x));
            chk("y", 32'(y), 32'(ex_y));
            chk("colour", 32'(colour), 32'(ex_c));
            if (plot === 1'b1) begin
                n_plot++;
                if (colour != C_EMPTY && colour != C_GRID) n_other++;
                if (colour == C_P1) begin
                    red_n++;
                    if (int'(x) < red_minx) red_minx = int'(x);
                    if (int'(x) > red_maxx) red_maxx = int'(x);
                    if (int'(y) < red_miny) red_miny = int'(y);
                    if (int'(y) > red_maxy) red_maxy = int'(y);
                end
                if (x == 8'd87 && y == 7'd107) grid_c = colour;
            end
            if (draw_done === 1'b1) begin
                n_done++;
                done_t = cyc - acc + 1;
            end
            if (busy === 1'b1) begin
                n_busy++;
                addr_seen[ram_addr] = 1'b1;
            end
        end
    end

    int cur;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        while (cur < k) begin
            tick();
            cur++;
        end
    endtask

    task automatic pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        cur++;
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, "_plots"}, 32'(n_plot), 32'd10752);
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_t), 32'd10837);
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd10836);
    endtask

    initial begin
        int n_addr, n_bad;
        clear_stats();
        for (int i = 0; i < 64; i++) mem[i] = C_EMPTY;

        // Reset held two cycles with start also high: reset wins.
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        repeat (20) tick();
        chk("idle_plots", 32'(n_plot), 32'd0);
        chk("idle_busy", 32'(n_busy), 32'd0);

        // Frame A: empty board, restarts ignored mid-draw and during DONE.
        clear_stats();
        pulse();
        cur = 1;
        goto(5);
        pulse();
        goto(5000);
        pulse();
        goto(10837);
        start = 1'b1;
        tick();
        frame_checks("A");
        chk("A_non_empty_colours", 32'(n_other), 32'd0);
        n_addr = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (addr_seen[i]) begin
                n_addr++;
                if (i % 8 == 7 || i >= 48) n_bad++;
            end
        end
        chk("A_distinct_addrs", 32'(n_addr), 32'd42);
        chk("A_illegal_addrs", 32'(n_bad), 32'd0);
        clear_stats();
        tick();
        start = 1'b0;
        cur = 1;

        // Frame B: one red piece at row 5 col 3, written before that cell is read.
        mem[43] = C_P1;
        goto(10838);
        frame_checks("B");
        chk("B_red_count", 32'(red_n), 32'd225);
        chk("B_red_minx", 32'(red_minx), 32'd72);
        chk("B_red_maxx", 32'(red_maxx), 32'd86);
        chk("B_red_miny", 32'(red_miny), 32'd92);
        chk("B_red_maxy", 32'(red_maxy), 32'd106);
        chk("B_corner_grid", 32'(grid_c), 32'(3'b001));
        chk("B_non_empty_colours", 32'(n_other), 32'd225);

        // Frame C: random board, random ignored starts, late-cell write mid-frame.
        for (int i = 0; i < 64; i++) mem[i] = 3'($urandom_range(0, 7));
        repeat ($urandom_range(0, 5)) tick();
        clear_stats();
        pulse();
        cur = 1;
        goto($urandom_range(2, 5000));
        mem[41] = 3'($urandom_range(0, 7));
        for (int r = 0; r < 2; r++) begin
            goto(cur + $urandom_range(1, 2500));
            pulse();
        end
        goto(10839);
        frame_checks("C");

        // Frame D: random board, reset mid-draw, then a clean redraw.
        for (int i = 0; i < 64; i++) mem[i] = 3'($urandom_range(0, 7));
        clear_stats();
        pulse();
        cur = 1;
        goto(2999);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        cur = 3000;
        goto(3010);
        chk("D_no_done_after_reset", 32'(n_done), 32'd0);
        clear_stats();
        pulse();
        cur = 1;
        goto(10839);
        frame_checks("D");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
